// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
// Optional ovf signal exists only when PADD_OVF_EN is defined.
interface pipelined_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
`ifdef PADD_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
`else
    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out
    );
`endif
endinterface

// File: rtl/pipelined_addsub.sv
// Segmented add/sub pipeline: one SEG_W-bit carry segment per stage.
// Define PADD_OVF_EN to add the signed-overflow output.
module pipelined_addsub #(
    parameter int WIDTH = 16,
    parameter int SEG_W = 4
) (
    input logic              clk,
    input logic              reset,
    pipelined_addsub_if.slave bus
);
    localparam int STAGES = WIDTH / SEG_W;
    localparam int OPS    = (STAGES > 1) ? STAGES - 1 : 1;

    logic              adv;
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] cy_r;
    logic [WIDTH-1:0]  res_r [STAGES];
    logic [WIDTH-1:0]  a_r   [OPS];
    logic [WIDTH-1:0]  b_r   [OPS];

    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  src_r [STAGES];
    logic [WIDTH-1:0]  n_res [STAGES];
    logic [SEG_W:0]    seg   [STAGES];
    logic [STAGES-1:0] src_c;
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] n_cy;

    assign adv           = !vld[STAGES-1] | bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = vld[STAGES-1];
    assign bus.sum       = res_r[STAGES-1];
    assign bus.c_out     = cy_r[STAGES-1];

    // Stage k consumes the beat held by stage k-1 and resolves segment k.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                src_a[k] = bus.a;
                src_b[k] = bus.sub ? ~bus.b : bus.b;
                src_r[k] = '0;
                src_c[k] = bus.sub | bus.c_in;
                src_v[k] = bus.in_valid;
            end else begin
                src_a[k] = a_r[(k > 0) ? k - 1 : 0];
                src_b[k] = b_r[(k > 0) ? k - 1 : 0];
                src_r[k] = res_r[(k > 0) ? k - 1 : 0];
                src_c[k] = cy_r[(k > 0) ? k - 1 : 0];
                src_v[k] = vld[(k > 0) ? k - 1 : 0];
            end
            seg[k] = {1'b0, src_a[k][k*SEG_W +: SEG_W]}
                   + {1'b0, src_b[k][k*SEG_W +: SEG_W]}
                   + {{SEG_W{1'b0}}, src_c[k]};
            n_res[k] = src_r[k];
            n_res[k][k*SEG_W +: SEG_W] = seg[k][SEG_W-1:0];
            n_cy[k] = seg[k][SEG_W];
        end
    end

`ifdef PADD_OVF_EN
    logic ovf_r;
    logic n_ovf;
    logic msb_a;
    logic msb_b;

    assign msb_a   = src_a[STAGES-1][WIDTH-1];
    assign msb_b   = src_b[STAGES-1][WIDTH-1];
    assign n_ovf   = (msb_a == msb_b)
                   & (n_res[STAGES-1][WIDTH-1] != msb_a);
    assign bus.ovf = ovf_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_r <= 1'b0;
        end else if (adv) begin
            ovf_r <= n_ovf;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            vld  <= '0;
            cy_r <= '0;
            for (int k = 0; k < STAGES; k++) begin
                res_r[k] <= '0;
            end
            for (int k = 0; k < OPS; k++) begin
                a_r[k] <= '0;
                b_r[k] <= '0;
            end
        end else if (adv) begin
            vld  <= src_v;
            cy_r <= n_cy;
            for (int k = 0; k < STAGES; k++) begin
                res_r[k] <= n_res[k];
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                a_r[k] <= src_a[k];
                b_r[k] <= src_b[k];
            end
        end
    end
endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed vectors, random streams,
// stalls and reset with beats in flight against an arithmetic model.
module tb_pipelined_addsub;
    localparam int W   = 16;
    localparam int SEG = 4;
    localparam int ST  = W / SEG;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pipelined_addsub_if #(.WIDTH(W)) bus ();

    pipelined_addsub #(
        .WIDTH(W),
        .SEG_W(SEG)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         c;
        logic         v;
    } res_t;

    res_t exp_q[$];

    function automatic res_t model(logic [W-1:0] a, logic [W-1:0] b,
                                   logic c, logic s);
        res_t   r;
        longint full;
        longint sr;
        longint lim;
        lim = longint'(1) << (W - 1);
        if (s) begin
            full = longint'(a) - longint'(b);
            sr   = longint'(signed'(a)) - longint'(signed'(b));
            r.c  = (full >= 0);
        end else begin
            full = longint'(a) + longint'(b) + longint'(c);
            sr   = longint'(signed'(a)) + longint'(signed'(b)) + longint'(c);
            r.c  = (full >= (longint'(1) << W));
        end
        r.sum = full[W-1:0];
        r.v   = (sr >= lim) || (sr < -lim);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a         = 16'h1111;
        bus.b         = 16'h2222;
        bus.c_in      = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        bus.in_valid = 1'b0;
        reset        = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        n_cmp++;
        if ({bus.sum, bus.c_out} !== {16'h0000, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_sum: got %h/%b want 0000/0",
                     bus.sum, bus.c_out);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
`ifdef PADD_OVF_EN
        n_cmp++;
        if (bus.ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ovf: got %b want 0", bus.ovf);
        end
`endif
        for (int i = 0; i < ST + 2; i++) begin
            tick();
            n_cmp++;
            if (bus.out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_accept: cycle %0d got out_valid %b want 0",
                         i, bus.out_valid);
            end
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [5];
        logic [W-1:0] vb [5];
        logic [W-1:0] vs [5];
        logic         vc [5];
        logic         vu [5];
        logic         vo [5];
        int           n;
        va = '{16'h1234, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0005};
        vb = '{16'h0FFF, 16'h0001, 16'h0001, 16'h0000, 16'h0005};
        vc = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vu = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vs = '{16'h2234, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
        vo = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.a        = va[i];
            bus.b        = vb[i];
            bus.c_in     = vc[i];
            bus.sub      = vu[i];
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            n = 1;
            while (!bus.out_valid && n < 20) begin
                tick();
                n++;
            end
            n_cmp++;
            if (n !== ST) begin
                n_bad++;
                $display("FAIL dir_latency[%0d]: got %0d cycles want %0d",
                         i, n, ST);
            end
            n_cmp++;
            if ({bus.sum, bus.c_out} !== {vs[i], vo[i]}) begin
                n_bad++;
                $display("FAIL dir_result[%0d]: got %h/%b want %h/%b",
                         i, bus.sum, bus.c_out, vs[i], vo[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int   sent  = 0;
        int   got   = 0;
        int   first = -1;
        int   last  = -1;
        res_t e;
        exp_q.delete();
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 100 + ST + 20 && got < 100; cyc++) begin
            bus.in_valid = (sent < 100);
            bus.a        = W'($urandom);
            bus.b        = W'($urandom);
            bus.c_in     = 1'($urandom);
            bus.sub      = 1'($urandom);
            #1;
            if (bus.out_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL b2b_extra: got beat %h want none", bus.sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.sum, bus.c_out} !== {e.sum, e.c}) begin
                        n_bad++;
                        $display("FAIL b2b_result[%0d]: got %h/%b want %h/%b",
                                 got, bus.sum, bus.c_out, e.sum, e.c);
                    end
`ifdef PADD_OVF_EN
                    n_cmp++;
                    if (bus.ovf !== e.v) begin
                        n_bad++;
                        $display("FAIL b2b_ovf[%0d]: got %b want %b",
                                 got, bus.ovf, e.v);
                    end
`endif
                end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.a, bus.b, bus.c_in, bus.sub));
                sent++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (got !== 100) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d beats want 100", got);
        end
        n_cmp++;
        if (last - first !== 99) begin
            n_bad++;
            $display("FAIL b2b_rate: got span %0d want 99", last - first);
        end
    endtask

    task automatic test_stall();
        int           sent   = 0;
        int           got    = 0;
        int           stalls = 0;
        logic         have   = 1'b0;
        logic         held   = 1'b0;
        logic [W-1:0] hs     = '0;
        logic         hc     = 1'b0;
        res_t         e;
        exp_q.delete();
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            bus.out_ready = !(cyc >= 6 && cyc < 11);
            if (!have && sent < 8) begin
                bus.a    = W'($urandom);
                bus.b    = W'($urandom);
                bus.c_in = 1'($urandom);
                bus.sub  = 1'($urandom);
                have     = 1'b1;
            end
            bus.in_valid = have;
            #1;
            if (bus.out_valid && !bus.out_ready) begin
                stalls++;
                if (!held) begin
                    hs   = bus.sum;
                    hc   = bus.c_out;
                    held = 1'b1;
                end else begin
                    n_cmp++;
                    if ({bus.sum, bus.c_out} !== {hs, hc}) begin
                        n_bad++;
                        $display("FAIL stall_hold: got %h/%b want %h/%b",
                                 bus.sum, bus.c_out, hs, hc);
                    end
                end
                n_cmp++;
                if (bus.in_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL stall_in_ready: got %b want 0",
                             bus.in_ready);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL stall_extra: got beat %h want none",
                             bus.sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.sum, bus.c_out} !== {e.sum, e.c}) begin
                        n_bad++;
                        $display("FAIL stall_result[%0d]: got %h/%b want %h/%b",
                                 got, bus.sum, bus.c_out, e.sum, e.c);
                    end
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.a, bus.b, bus.c_in, bus.sub));
                sent++;
                have = 1'b0;
            end
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n_cmp++;
        if (got !== 8 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL stall_count: got %0d beats (%0d left) want 8 (0)",
                     got, exp_q.size());
        end
        n_cmp++;
        if (stalls !== 5) begin
            n_bad++;
            $display("FAIL stall_cycles: got %0d want 5", stalls);
        end
    endtask

    task automatic test_reset_flight();
        int seen = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.a        = W'($urandom);
            bus.b        = W'($urandom);
            bus.c_in     = 1'($urandom);
            bus.sub      = 1'($urandom);
            bus.in_valid = 1'b1;
            tick();
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flight_reset: got out_valid %b want 0",
                     bus.out_valid);
        end
        bus.in_valid = 1'b0;
        reset        = 1'b0;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL flight_in_ready: got %b want 1", bus.in_ready);
        end
        for (int i = 0; i < ST + 3; i++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL flight_stale: got %0d beats want 0", seen);
        end
    endtask

`ifdef PADD_OVF_EN
    task automatic test_ovf();
        logic [W-1:0] va [4];
        logic [W-1:0] vb [4];
        logic         vu [4];
        logic         vo [4];
        int           n;
        va = '{16'h7FFF, 16'h8000, 16'h0001, 16'h8000};
        vb = '{16'h0001, 16'h0001, 16'h0001, 16'h8000};
        vu = '{1'b0, 1'b1, 1'b0, 1'b0};
        vo = '{1'b1, 1'b1, 1'b0, 1'b1};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.a        = va[i];
            bus.b        = vb[i];
            bus.c_in     = 1'b0;
            bus.sub      = vu[i];
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            n = 1;
            while (!bus.out_valid && n < 20) begin
                tick();
                n++;
            end
            n_cmp++;
            if (!bus.out_valid || bus.ovf !== vo[i]) begin
                n_bad++;
                $display("FAIL ovf[%0d]: got valid %b ovf %b want 1/%b",
                         i, bus.out_valid, bus.ovf, vo[i]);
            end
            tick();
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.c_in      = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_flight();
`ifdef PADD_OVF_EN
        test_ovf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
